// File: rtl/tcore_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tcore_param (package)
// Purpose  : Shared types and constants for the configurable UART transmitter.
//            - uart_tx_state_e : transmitter FSM states
//            - uart_dbits_e    : data-width selector encoding (5..8 bits)
//            - UART_FIFO_DEPTH_DEF : default TX FIFO depth
//            - dbits_mask()    : keeps only the bits that go on the wire
// Revision : 1.0 - initial release
// ============================================================================
package tcore_param;

    localparam int UART_FIFO_DEPTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } uart_tx_state_e;

    typedef enum logic [1:0] {
        DBITS_5 = 2'b00,
        DBITS_6 = 2'b01,
        DBITS_7 = 2'b10,
        DBITS_8 = 2'b11
    } uart_dbits_e;

    // Bits of the byte that are actually transmitted (and enter the parity).
    function automatic logic [7:0] dbits_mask(input uart_dbits_e dbits);
        logic [7:0] mask;
        case (dbits)
            DBITS_5: mask = 8'h1F;
            DBITS_6: mask = 8'h3F;
            DBITS_7: mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous show-ahead FIFO holding bytes waiting to be sent.
//            Pointers carry one extra wrap bit so full/empty need no counter.
// Ports    : clk_i, rst_ni (async, active-low)
//            push_i/din_i  - write strobe and data (dropped when full)
//            pop_i/dout_o  - advance read pointer / head entry (show-ahead)
//            full_o, empty_o, level_o - fill status
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    // Same slot, opposite lap: writer is a full lap ahead of the reader.
    assign full_o  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign level_o = r_wr_ptr - r_rd_ptr;
    assign dout_o  = r_mem[r_rd_ptr[c_aw-1:0]];

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_aw + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= din_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Purpose  : Configurable UART transmitter: 5-8 data bits, optional even/odd
//            parity, 1 or 2 stop bits, break generation, TX FIFO.
// Ports    : clk_i, rst_ni (async, active-low)
//            baud_div_i   - clocks per bit (0 behaves as 1)
//            tx_en_i      - enables the baud generator (0 freezes the line)
//            data_bits_i, parity_en_i, parity_odd_i, stop2_i - frame format,
//                           sampled when a frame is loaded
//            break_i      - hold line low between frames
//            tx_we_i/din_i - FIFO write
//            full_o, empty_o, level_o - FIFO status
//            busy_o       - FSM not idle
//            tx_done_o    - one-cycle pulse at the end of the last stop bit
//            tx_bit_o     - registered serial line
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import tcore_param::*;
#(
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH_DEF,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [DIV_W-1:0]              baud_div_i,
    input  logic                          tx_en_i,
    input  logic [1:0]                    data_bits_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    input  logic                          break_i,
    input  logic                          tx_we_i,
    input  logic [7:0]                    din_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          tx_done_o,
    output logic                          tx_bit_o
);

    // ---------------------------------------------------------------- FIFO
    logic       w_load;
    logic [7:0] w_fifo_dout;
    logic [7:0] w_mask;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_we_i),
        .din_i   (din_i),
        .pop_i   (w_load),
        .dout_o  (w_fifo_dout),
        .full_o  (full_o),
        .empty_o (empty_o),
        .level_o (level_o)
    );

    assign w_mask = dbits_mask(uart_dbits_e'(data_bits_i));

    // -------------------------------------------------------- baud generator
    logic [DIV_W-1:0] r_baud_cnt;
    logic [DIV_W-1:0] w_div_m1;
    logic             w_tick;

    assign w_div_m1 = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
    // '>=' so that lowering the divisor on the fly cannot strand the counter
    // above the terminal count for a full 2^DIV_W wrap.
    assign w_tick   = tx_en_i && (r_baud_cnt >= w_div_m1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_baud_cnt <= '0;
        end else if (!tx_en_i || w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------ FSM state
    uart_tx_state_e r_state;
    uart_tx_state_e w_state_nx;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_nx;
    logic [2:0]     r_bit_cnt;
    logic [2:0]     w_bit_cnt_nx;
    logic [2:0]     r_nbits_m1;
    logic           r_par_en;
    logic           r_par_bit;
    logic           r_stop2;
    logic           r_tx_bit;
    logic           r_done;
    logic           w_line_nx;
    logic           w_stop_end;

    // Process 1: state and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_nbits_m1 <= 3'd7;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx_bit   <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_tx_bit  <= w_line_nx;
            r_done    <= w_stop_end;
            if (w_load) begin
                // Frame format is frozen here for the whole frame.
                r_shift    <= w_fifo_dout & w_mask;
                r_nbits_m1 <= {1'b1, data_bits_i};
                r_par_en   <= parity_en_i;
                r_par_bit  <= (^(w_fifo_dout & w_mask)) ^ parity_odd_i;
                r_stop2    <= stop2_i;
            end else begin
                r_shift    <= w_shift_nx;
            end
        end
    end

    // Process 2: next-state logic; everything advances only on a baud tick.
    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_bit_cnt_nx = r_bit_cnt;
        w_load       = 1'b0;
        w_stop_end   = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (break_i) begin
                        w_state_nx = BRK;
                    end else if (!empty_o) begin
                        w_load     = 1'b1;
                        w_state_nx = START;
                    end
                end
                START: begin
                    w_state_nx   = DATA;
                    w_bit_cnt_nx = 3'd0;
                end
                DATA: begin
                    if (r_bit_cnt == r_nbits_m1) begin
                        w_bit_cnt_nx = 3'd0;
                        w_state_nx   = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                    end
                end
                PARITY: begin
                    w_state_nx   = STOP;
                    w_bit_cnt_nx = 3'd0;
                end
                STOP: begin
                    if (r_stop2 && (r_bit_cnt == 3'd0)) begin
                        w_bit_cnt_nx = 3'd1;
                    end else begin
                        w_stop_end = 1'b1;
                        if (break_i) begin
                            w_state_nx = BRK;
                        end else if (!empty_o) begin
                            // Back-to-back: next start bit follows directly.
                            w_load     = 1'b1;
                            w_state_nx = START;
                        end else begin
                            w_state_nx = IDLE;
                        end
                    end
                end
                BRK: begin
                    if (!break_i) begin
                        w_state_nx = IDLE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    // Process 3: line level for the state being entered, so tx_bit_o
    // changes on the same edge as the state.
    always_comb begin
        case (w_state_nx)
            START:   w_line_nx = 1'b0;
            DATA:    w_line_nx = w_shift_nx[0];
            PARITY:  w_line_nx = r_par_bit;
            BRK:     w_line_nx = 1'b0;
            default: w_line_nx = 1'b1;
        endcase
    end

    assign busy_o    = (r_state != IDLE);
    assign tx_done_o = r_done;
    assign tx_bit_o  = r_tx_bit;

endmodule

`default_nettype wire
